// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: round-robin arbiter that collects one packet at a time
// from NREQ acquisition sources into a packet RAM (header word first).
// It then hands the packet to the USB slave-FIFO transmit path, which
// drains the RAM through an address-driven read port.
module usb_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int DATA_NBIT     = 16,
    parameter int ADDR_NBIT     = 9,
    parameter int GAP_CYCLES    = 4,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic                      ifclk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    output logic [NREQ-1:0]           gnt,
    input  logic [NREQ-1:0]           src_vd,
    input  logic [NREQ*DATA_NBIT-1:0] src_data,
    output logic                      tx_cache_sop,
    input  logic [ADDR_NBIT-1:0]      tx_cache_addr,
    output logic [DATA_NBIT-1:0]      tx_cache_data,
    output logic                      busy,
    output logic [2:0]                cur_ch,
    output logic [15:0]               pkt_cnt,
    output logic                      err_timeout
);

    localparam int DEPTH    = 1 << ADDR_NBIT;
    localparam int TMR_NBIT = $clog2(DRAIN_TIMEOUT);
    localparam int GAP_NBIT = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FILL,
        S_SOP,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t                 state_reg;
    logic [2:0]             last_ch_reg;
    logic [7:0]             seq_reg;
    logic [ADDR_NBIT-1:0]   wptr_reg;
    logic                   pad_reg;
    logic [TMR_NBIT-1:0]    tmr_reg;
    logic [GAP_NBIT-1:0]    gap_reg;

    // Packet RAM: one write port (fill side), one registered read port.
    logic [DATA_NBIT-1:0]   pkt_ram [DEPTH];
    logic                   ram_we;
    logic [ADDR_NBIT-1:0]   ram_waddr;
    logic [DATA_NBIT-1:0]   ram_wdata;

    // Per-source views widened to 8 entries so the 3-bit cur_ch indexes them exactly.
    logic [DATA_NBIT-1:0]   src_word [8];
    logic [7:0]             req_ext;
    logic [7:0]             vd_ext;

    logic [2:0]             winner;
    logic                   any_req;
    logic                   fill_pad;
    logic                   fill_wr;
    logic [15:0]            hdr_word;

    assign req_ext = 8'(req);
    assign vd_ext  = 8'(src_vd);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_src
            if (gi < NREQ) begin : g_used
                assign src_word[gi] = src_data[gi*DATA_NBIT +: DATA_NBIT];
            end else begin : g_unused
                assign src_word[gi] = '0;
            end
        end
    endgenerate

    // Round-robin pick: lowest requesting index above last_ch, else lowest overall.
    always_comb begin
        logic [2:0] win_hi;
        logic [2:0] win_lo;
        logic       found_hi;
        logic       found_lo;
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int c = NREQ - 1; c >= 0; c--) begin
            if (req[c]) begin
                if (3'(c) > last_ch_reg) begin
                    found_hi = 1'b1;
                    win_hi   = 3'(c);
                end else begin
                    found_lo = 1'b1;
                    win_lo   = 3'(c);
                end
            end
        end
        any_req = found_hi | found_lo;
        winner  = found_hi ? win_hi : win_lo;
    end

    // Once the granted source drops its request, the rest of the packet is zero padding.
    assign fill_pad = pad_reg | ~req_ext[cur_ch];
    assign fill_wr  = (state_reg == S_FILL) && (fill_pad || vd_ext[cur_ch]);
    assign hdr_word = {4'hA, 1'b0, cur_ch, seq_reg};

    // RAM write-port decode: header in HDR, payload or padding in FILL.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wptr_reg;
        ram_wdata = '0;
        if (state_reg == S_HDR) begin
            ram_we    = 1'b1;
            ram_waddr = '0;
            ram_wdata = DATA_NBIT'(hdr_word);
        end else if (fill_wr) begin
            ram_we    = 1'b1;
            ram_wdata = fill_pad ? '0 : src_word[cur_ch];
        end
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge ifclk) begin
        if (ram_we) begin
            pkt_ram[ram_waddr] <= ram_wdata;
        end
    end

    // Read port is always live so the slave FIFO can read in any state.
    always_ff @(posedge ifclk or posedge rst) begin
        if (rst) begin
            tx_cache_data <= '0;
        end else begin
            tx_cache_data <= pkt_ram[tx_cache_addr];
        end
    end

    // Main controller: grant, fill, announce, drain, then idle gap.
    always_ff @(posedge ifclk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            gnt          <= '0;
            tx_cache_sop <= 1'b0;
            busy         <= 1'b0;
            cur_ch       <= '0;
            pkt_cnt      <= '0;
            err_timeout  <= 1'b0;
            seq_reg      <= '0;
            last_ch_reg  <= 3'(NREQ - 1);
            wptr_reg     <= '0;
            pad_reg      <= 1'b0;
            tmr_reg      <= '0;
            gap_reg      <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (any_req) begin
                        gnt         <= NREQ'(1) << winner;
                        cur_ch      <= winner;
                        last_ch_reg <= winner;
                        busy        <= 1'b1;
                        state_reg   <= S_HDR;
                    end
                end
                S_HDR: begin
                    wptr_reg  <= ADDR_NBIT'(1);
                    pad_reg   <= 1'b0;
                    state_reg <= S_FILL;
                end
                S_FILL: begin
                    pad_reg <= fill_pad;
                    if (fill_wr) begin
                        wptr_reg <= wptr_reg + 1'b1;
                        if (wptr_reg == '1) begin
                            gnt          <= '0;
                            tx_cache_sop <= 1'b1;
                            state_reg    <= S_SOP;
                        end
                    end
                end
                S_SOP: begin
                    tx_cache_sop <= 1'b0;
                    tmr_reg      <= '0;
                    state_reg    <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (tx_cache_addr == '1) begin
                        pkt_cnt   <= pkt_cnt + 1'b1;
                        seq_reg   <= seq_reg + 1'b1;
                        gap_reg   <= '0;
                        state_reg <= S_GAP;
                    end else if (tmr_reg == TMR_NBIT'(DRAIN_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        gap_reg     <= '0;
                        state_reg   <= S_GAP;
                    end else begin
                        tmr_reg <= tmr_reg + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_reg == GAP_NBIT'(GAP_CYCLES - 1)) begin
                        busy      <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        gap_reg <= gap_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                    gnt       <= '0;
                end
            endcase
        end
    end

endmodule
